// File: rtl/parity_pkg.sv
// Shared constants and FSM state type for the serial parity checker.
package parity_pkg;
   localparam int W_DEF          = 16;
   localparam int CNT_W_DEF      = 8;
   localparam int PARITY_ODD_DEF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_t;
endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of a W-bit word, inverted when odd parity is selected.
module parity_reduce
   import parity_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int PARITY_ODD = PARITY_ODD_DEF
) (
   input  logic [W-1:0] i_data,
   output logic         o_par
);
   assign o_par = (^i_data) ^ PARITY_ODD[0];
endmodule

// File: rtl/parity_checker.sv
// Serial-in parity checker: LSB-first deserialiser, parity check, valid/ready output, error counter.
// Macro PARITY_CHECK_DROP_EN: when defined, frames with a parity error are counted but never presented.
module parity_checker
   import parity_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int PARITY_ODD = PARITY_ODD_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             sof,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_perr,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             err_clr,
   output logic             overrun
);
   localparam int BW = $clog2(W + 1);

   state_t           r_state;
   logic [W-1:0]     r_shift;
   logic [BW-1:0]    r_bitcnt;
   logic [W-1:0]     r_out_data;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_overrun;

   logic w_calc_par;
   logic w_perr;
   logic w_done;
   logic w_present;
   logic w_load;

   parity_reduce #(
      .W          (W),
      .PARITY_ODD (PARITY_ODD)
   ) u_reduce (
      .i_data (r_shift),
      .o_par  (w_calc_par)
   );

   assign w_done = (r_state == PAR) && ser_valid && !sof;
   assign w_perr = w_calc_par ^ ser_in;
   assign w_load = w_present && (!r_out_valid || out_ready);

`ifdef PARITY_CHECK_DROP_EN
   assign w_present = w_done && !w_perr;
   assign out_perr  = 1'b0;
`else
   logic r_out_perr;

   assign w_present = w_done;
   assign out_perr  = r_out_perr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_perr <= 1'b0;
      end else if (w_load) begin
         r_out_perr <= w_perr;
      end
   end
`endif

   // Right shift: the first (LSB) bit enters at the MSB and lands in bit 0 after W shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else if (ser_valid) begin
         if (sof) begin
            r_shift  <= {ser_in, {(W-1){1'b0}}};
            r_bitcnt <= BW'(1);
            r_state  <= DATA;
         end else begin
            case (r_state)
               DATA: begin
                  r_shift  <= {ser_in, r_shift[W-1:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == BW'(W - 1)) begin
                     r_state <= PAR;
                  end
               end
               PAR: begin
                  r_state  <= IDLE;
                  r_bitcnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_err_cnt   <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_data  <= r_shift;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         // Clear takes priority over a same-cycle increment or overrun.
         if (err_clr) begin
            r_err_cnt <= '0;
            r_overrun <= 1'b0;
         end else begin
            if (w_done && w_perr && (r_err_cnt != {CNT_W{1'b1}})) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_present && r_out_valid && !out_ready) begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign err_cnt   = r_err_cnt;
   assign overrun   = r_overrun;
endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
- Serial-in parity checker. It is the receive-side counterpart of the team's 16-bit even-parity generator.
- Deserialises frames of W data bits, LSB first, followed by one parity bit.
- Recomputes parity, flags mismatches, and presents each word downstream on a valid/ready handshake.
- Maintains a saturating parity-error counter and a sticky overrun flag for status readback.

Parameters:
- W, 16: data bits per frame.
- PARITY_ODD, 0: 0 = even parity (XOR of data bits equals the parity bit); 1 = odd parity.
- CNT_W, 8: width of the error counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled on this cycle.
- sof  input  1  start of frame; qualified by ser_valid, marks data bit 0.
- out_data  output  W  received data word.
- out_valid  output  1  out_data, out_perr valid.
- out_ready  input  1  downstream accepts the word.
- out_perr  output  1  parity mismatch for the presented word.
- err_cnt  output  CNT_W  saturating count of parity-error frames.
- err_clr  input  1  synchronous clear of err_cnt and overrun.
- overrun  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; shift register and bit counter are cleared.
  - out_data=0, out_valid=0, out_perr=0, err_cnt=0, overrun=0.
  - Reset mid-frame discards the partial frame.
- FSM states: IDLE, DATA, PAR.
  - IDLE: ser_valid&&sof → store bit 0, bit count=1, go to DATA. ser_valid without sof is ignored.
  - DATA: each ser_valid shifts ser_in into bit[count], count++. After bit W-1 is stored, go to PAR.
  - PAR: the next ser_valid samples the parity bit, completes the frame, and returns to IDLE.
  - Cycles without ser_valid hold state; there is no timeout.
- sof with ser_valid while in DATA or PAR aborts the current frame. That bit becomes bit 0 of a new frame (count=1, state DATA). Nothing is counted for the aborted frame.
- Frame completion:
  - perr = (^data) ^ PARITY_ODD ^ parity_bit.
  - Latency: out_valid rises the cycle after the parity bit is sampled.
  - out_data/out_perr are loaded from a holding register separate from the shift register, so reception continues while a word waits.
- Handshake:
  - out_valid stays high and out_data/out_perr stay stable until a cycle with out_valid&&out_ready.
  - out_valid falls the next cycle unless a new frame completes in that same cycle. In that case the new word loads and out_valid stays 1.
- Overrun: a frame completes while out_valid=1 and out_ready=0.
  - The new frame is dropped and the held word is kept.
  - overrun is set (sticky).
  - A parity error on the dropped frame is still counted.
- err_cnt:
  - +1 per completed frame with perr=1; saturates at 2^CNT_W-1.
  - err_clr clears err_cnt and overrun. err_clr wins over a simultaneous increment or set (result 0).

Optional Feature:
- Macro PARITY_CHECK_DROP_EN.
  - Defined: frames with perr=1 are counted but never presented; out_valid is not asserted for them and out_perr is constant 0. Such frames also cannot cause an overrun.
  - Undefined: all frames are presented, with out_perr indicating a mismatch.

Decomposition:
- Package parity_pkg: default W and CNT_W constants, FSM state enum (IDLE/DATA/PAR), PARITY_ODD default.
- One sub-module, parity_reduce: combinational W-bit XOR reduction with a PARITY_ODD parameter, instantiated once on the assembled word.
- FSM, handshake and counter stay in parity_checker.

Test Plan:
- Frame 0xA5A5, parity 0, out_ready=1 → out_data=0xA5A5, out_perr=0, out_valid 1 cycle after the parity bit, err_cnt=0.
- Frame 0x0001, parity 0 → out_perr=1, err_cnt=1. With PARITY_CHECK_DROP_EN: no out_valid, err_cnt=1.
- out_ready=0, frames 0x1234 then 0x00FF, both good → out_data holds 0x1234 and overrun=1. Raising out_ready yields 0x1234 only. err_clr → overrun=0.
- sof reasserted after 5 bits, then a full frame 0xBEEF with correct parity → single output 0xBEEF, perr=0, err_cnt unchanged.
- CNT_W=2, four bad frames → err_cnt saturates at 3. err_clr coinciding with a fifth bad frame → err_cnt=0.
- rst_n low for 1 cycle after 8 data bits, then a full frame 0x5555 → outputs reset to 0 during reset, followed by exactly one word 0x5555.
